regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
// - Command-driven master for the register_file write port (we3/a3/wd3) and read port 1 (a1/rd1).
// - Accepts single/burst fill, clear and read commands over a valid/ready channel.
// - Streams read data out over a valid/ready response channel.
// - Sits between the debug/boot loader and the core's register_file; sole owner of those ports while the core is halted.
// PARAMETERS
// - REGISTERS  32                   number of registers in the target register_file
// - WIDTH      32                   register data width
// - AW         $clog2(REGISTERS)    register address width
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       asynchronous active-low reset
// - cmd_valid  in   1       command present
// - cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
// - cmd_op     in   2       00 FILL, 01 READ, 10 CLEAR, 11 reserved
// - cmd_addr   in   AW      start register
// - cmd_count  in   AW+1    number of registers, legal 1..REGISTERS
// - cmd_data   in   WIDTH   FILL value
// - rsp_valid  out  1       read response present
// - rsp_ready  in   1       downstream accepts response
// - rsp_data   out  WIDTH   register contents
// - rsp_addr   out  AW      register the data came from
// - rsp_last   out  1       final beat of a READ burst
// - rf_we3     out  1       register_file write enable
// - rf_a3      out  AW      register_file write address
// - rf_wd3     out  WIDTH   register_file write data
// - rf_a1      out  AW      register_file read address
// - rf_rd1     in   WIDTH   register_file read data (combinational from rf_a1)
// - busy       out  1       state != IDLE
// - err        out  1       one-cycle pulse on an illegal command
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE.
//   - cmd_ready=1; rsp_valid=0; rsp_last=0; rsp_data=0; rsp_addr=0.
//   - rf_we3=0; rf_a3=0; rf_wd3=0; rf_a1=0; busy=0; err=0.
//   - Reset mid-burst aborts the burst; no further writes, pending response dropped.
// - FSM states: IDLE, FILL, READ, DRAIN.
// - IDLE: cmd_ready=1; all other states drive cmd_ready=0.
// - Command handshake at edge k:
//   - Illegal command (cmd_count==0, cmd_count>REGISTERS, or op 11): err=1 for cycle k+1, stay IDLE, no rf activity.
//   - FILL/CLEAR: load cur_addr=cmd_addr, remaining=cmd_count, wdata=(CLEAR ? 0 : cmd_data); go to FILL.
//   - READ: load cur_addr and remaining; go to READ.
// - FILL:
//   - rf_we3=1, rf_a3=cur_addr, rf_wd3=wdata every cycle; all three registered outputs.
//   - First write edge is k+2; one register per cycle; no back-pressure.
//   - After the beat with remaining==1, rf_we3 drops and state returns to IDLE.
// - READ:
//   - rf_a1=cur_addr.
//   - Response register loads when !rsp_valid || rsp_ready: rsp_data=rf_rd1, rsp_addr=cur_addr, rsp_last=(remaining==1).
//   - Each load advances cur_addr and decrements remaining.
//   - First rsp_valid seen after edge k+1; 1 beat/cycle while rsp_ready=1.
//   - rsp_valid/data/addr/last hold stable while rsp_ready=0.
//   - After loading the last beat, go to DRAIN.
// - DRAIN: wait for the last-beat handshake; rsp_valid=0 and IDLE at the next edge.
// - Address arithmetic:
//   - cur_addr+1 wraps to 0 after REGISTERS-1, computed modulo REGISTERS (REGISTERS need not be 2^AW).
//   - Bursts wrap: addr 30, count 4 -> 30, 31, 0, 1.
// - Address 0 is not special-cased; the register_file decides x0 semantics.
// - rf_we3 is never asserted in READ or DRAIN; rf_a1 is don't-care outside READ.
// PACKAGE AND SUB-MODULES
// - Package regfile_access_pkg:
//   - op_e (FILL/READ/CLEAR/RSVD) and state_e enums.
//   - Function next_addr(addr) implementing the modulo-REGISTERS wrap.
// - Single module; the response register is inline, no sub-module.
// - Bench instantiates register_file (REGISTERS=32, WIDTH=32) as the target.
// TESTING
// 1. FILL addr=5 count=1 data=32'hABCDE123, then READ addr=5 count=1 -> one beat, rsp_data=ABCDE123, rsp_addr=5, rsp_last=1.
// 2. FILL addr=7 count=3 data=32'h12345678 -> rf_we3 high exactly 3 cycles, a3=7,8,9; READ 7/3 returns 3 beats of 12345678, rsp_last only on addr 9.
// 3. READ addr=30 count=4 with rsp_ready toggling 1,0,0,1,... -> addresses 30,31,0,1 in order; data held stable while stalled; no beat lost or duplicated.
// 4. Illegal commands (count=0, count=33, op=11) -> err pulses 1 cycle each; cmd_ready stays 1; rf_we3 never rises.
// 5. CLEAR addr=0 count=32 after filling every register with 32'hFFFFFFFF, then READ 0/32 -> all 32 beats return 0.
// 6. Assert rst_n=0 mid FILL 0/32 at the 10th write -> rf_we3 and busy drop asynchronously; registers 10..31 keep their prior values.

Source files
------------

// File: rtl/regfile_access_pkg.sv
// Shared types and address helpers for the register-file access controller.
package regfile_access_pkg;

  typedef enum logic [1:0] {
    OP_FILL  = 2'b00,
    OP_READ  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_READ  = 2'b10,
    ST_DRAIN = 2'b11
  } state_e;

  // Wraps at regs, which need not be a power of two.
  function automatic int unsigned next_addr(
    input int unsigned addr,
    input int unsigned regs = 32
  );
    return (addr + 1 >= regs) ? 32'd0 : addr + 1;
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Command and response channels of the register-file access controller.
interface regfile_access_ctrl_if
  import regfile_access_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [AW:0]      cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [AW-1:0]    rsp_addr;
  logic             rsp_last;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr,
    input  cmd_count, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data,
    output rsp_addr, rsp_last
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr,
    output cmd_count, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data,
    input  rsp_addr, rsp_last
  );
endinterface

// File: rtl/register_file.sv
// Target register file: one sync write port, one combinational read port.
module register_file #(
  parameter int REGISTERS = 32,
  parameter int WIDTH     = 32,
  parameter int AW        = $clog2(REGISTERS)
) (
  input  logic             clk,
  input  logic             we3,
  input  logic [AW-1:0]    a3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    a1,
  output logic [WIDTH-1:0] rd1
);
  logic [WIDTH-1:0] regs [REGISTERS];

  always_ff @(posedge clk)
    if (we3) regs[a3] <= wd3;

  assign rd1 = regs[a1];
endmodule

// File: rtl/regfile_access_ctrl.sv
// Command-driven master for the register file write port and read port 1.
module regfile_access_ctrl
  import regfile_access_pkg::*;
#(
  parameter int REGISTERS = 32,
  parameter int WIDTH     = 32,
  parameter int AW        = $clog2(REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_access_ctrl_if.slave  bus,
  output logic                  rf_we3,
  output logic [AW-1:0]         rf_a3,
  output logic [WIDTH-1:0]      rf_wd3,
  output logic [AW-1:0]         rf_a1,
  input  logic [WIDTH-1:0]      rf_rd1,
  output logic                  busy,
  output logic                  err
);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FILL  = ST_FILL;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [AW:0] ONE    = (AW+1)'(1);
  localparam logic [AW:0] MAXCNT = (AW+1)'(REGISTERS);

  logic [1:0]       state;
  logic [AW-1:0]    cur_addr;
  logic [AW-1:0]    nxt;
  logic [AW:0]      remaining;
  logic [WIDTH-1:0] wdata;
  logic             take;
  logic             illegal;
  logic             load;
  logic             last_one;
  logic             rsp_hs;

  assign bus.cmd_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign rf_a1    = cur_addr;
  assign take     = bus.cmd_valid && bus.cmd_ready;
  assign illegal  = (bus.cmd_op == OP_RSVD)
                 || (bus.cmd_count == '0)
                 || (bus.cmd_count > MAXCNT);
  assign last_one = (remaining == ONE);
  assign rsp_hs   = bus.rsp_valid && bus.rsp_ready;
  assign load     = (state == S_READ)
                 && (!bus.rsp_valid || bus.rsp_ready);
  assign nxt      = AW'(next_addr(32'(cur_addr), REGISTERS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      wdata         <= '0;
      rf_we3        <= 1'b0;
      rf_a3         <= '0;
      rf_wd3        <= '0;
      err           <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_addr  <= '0;
      bus.rsp_last  <= 1'b0;
    end else begin
      err    <= 1'b0;
      rf_we3 <= 1'b0;
      if (rsp_hs) bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              cur_addr  <= bus.cmd_addr;
              remaining <= bus.cmd_count;
              wdata     <= (bus.cmd_op == OP_CLEAR)
                         ? '0 : bus.cmd_data;
              state     <= (bus.cmd_op == OP_READ)
                         ? S_READ : S_FILL;
            end
          end
        end
        S_FILL: begin
          rf_we3    <= 1'b1;
          rf_a3     <= cur_addr;
          rf_wd3    <= wdata;
          cur_addr  <= nxt;
          remaining <= remaining - ONE;
          if (last_one) state <= S_IDLE;
        end
        S_READ: begin
          // Response register refills whenever it is empty or draining.
          if (load) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= rf_rd1;
            bus.rsp_addr  <= cur_addr;
            bus.rsp_last  <= last_one;
            cur_addr      <= nxt;
            remaining     <= remaining - ONE;
            if (last_one) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rsp_hs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl driving a 32x32 register_file.
module tb_regfile_access_ctrl;
  import regfile_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_we3;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [4:0]  rf_a1;
  logic [31:0] rf_rd1;
  logic        busy;
  logic        err;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_access_ctrl_if #(.WIDTH(32), .AW(5)) bus ();

  regfile_access_ctrl #(
    .REGISTERS(32), .WIDTH(32), .AW(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .rf_a1(rf_a1), .rf_rd1(rf_rd1),
    .busy(busy), .err(err)
  );

  register_file #(
    .REGISTERS(32), .WIDTH(32), .AW(5)
  ) rf (
    .clk(clk), .we3(rf_we3), .a3(rf_a3), .wd3(rf_wd3),
    .a1(rf_a1), .rd1(rf_rd1)
  );

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(
    input op_e op, input int a, input int n,
    input logic [31:0] d
  );
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = 5'(a);
    bus.cmd_count = 6'(n);
    bus.cmd_data  = d;
    check("cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic fill(
    input op_e op, input int a, input int n,
    input logic [31:0] d
  );
    logic [31:0] exp;
    int ea;
    int cnt;
    exp = (op == OP_CLEAR) ? 32'd0 : d;
    ea  = a;
    cnt = 0;
    send_cmd(op, a, n, d);
    for (int i = 0; i < n + 4; i++) begin
      if (rf_we3) begin
        check("a3", 32'(rf_a3), ea);
        check("wd3", rf_wd3, exp);
        mem[ea] = exp;
        ea = (ea + 1) % 32;
        cnt++;
      end
      @(negedge clk);
    end
    check("we3_cycles", cnt, n);
    check("fill_busy", 32'(busy), 0);
  endtask

  task automatic read(input int a, input int n, input int mode);
    int beats;
    int ea;
    logic rdy;
    logic stalled;
    logic we_seen;
    logic [31:0] pd;
    logic [4:0]  pa;
    beats   = 0;
    stalled = 1'b0;
    we_seen = 1'b0;
    pd      = '0;
    pa      = '0;
    send_cmd(OP_READ, a, n, 32'd0);
    for (int cyc = 0; cyc < 200 && beats < n; cyc++) begin
      rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus.rsp_ready = rdy;
      we_seen |= rf_we3;
      if (bus.rsp_valid) begin
        if (stalled) begin
          check("hold_data", bus.rsp_data, pd);
          check("hold_addr", 32'(bus.rsp_addr), 32'(pa));
        end
        if (rdy) begin
          ea = (a + beats) % 32;
          check("rsp_addr", 32'(bus.rsp_addr), ea);
          check("rsp_data", bus.rsp_data, mem[ea]);
          check("rsp_last", 32'(bus.rsp_last),
                32'(beats == n - 1));
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = bus.rsp_data;
          pa = bus.rsp_addr;
        end
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    check("beats", beats, n);
    check("rsp_valid_end", 32'(bus.rsp_valid), 0);
    check("read_busy", 32'(busy), 0);
    check("we3_in_read", 32'(we_seen), 0);
  endtask

  task automatic illegal(input op_e op, input int a, input int n);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = 5'(a);
    bus.cmd_count = 6'(n);
    bus.cmd_data  = 32'hFEEDFACE;
    check("ill_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("ill_err", 32'(err), 1);
    check("ill_we3", 32'(rf_we3), 0);
    check("ill_busy", 32'(busy), 0);
    check("ill_ready2", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    check("ill_err_off", 32'(err), 0);
    check("ill_we3_2", 32'(rf_we3), 0);
  endtask

  initial begin
    logic found;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_FILL;
    bus.cmd_addr  = '0;
    bus.cmd_count = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    #12;
    check("rst_ready", 32'(bus.cmd_ready), 1);
    check("rst_rvalid", 32'(bus.rsp_valid), 0);
    check("rst_rlast", 32'(bus.rsp_last), 0);
    check("rst_rdata", bus.rsp_data, 0);
    check("rst_raddr", 32'(bus.rsp_addr), 0);
    check("rst_we3", 32'(rf_we3), 0);
    check("rst_a3", 32'(rf_a3), 0);
    check("rst_wd3", rf_wd3, 0);
    check("rst_a1", 32'(rf_a1), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    fill(OP_FILL, 5, 1, 32'hABCDE123);
    read(5, 1, 0);

    fill(OP_FILL, 7, 3, 32'h12345678);
    read(7, 3, 0);

    fill(OP_FILL, 30, 1, 32'hA0000030);
    fill(OP_FILL, 31, 1, 32'hA0000031);
    fill(OP_FILL, 0, 1, 32'hA0000000);
    fill(OP_FILL, 1, 1, 32'hA0000001);
    read(30, 4, 1);

    illegal(OP_FILL, 0, 0);
    illegal(OP_READ, 3, 33);
    illegal(OP_RSVD, 2, 1);

    fill(OP_FILL, 0, 32, 32'hFFFFFFFF);
    fill(OP_CLEAR, 0, 32, 32'hDEADBEEF);
    read(0, 32, 0);

    send_cmd(OP_FILL, 0, 32, 32'h5A5A5A5A);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rf_we3 && rf_a3 == 5'd10) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_point", 32'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_we3", 32'(rf_we3), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(bus.cmd_ready), 1);
    for (int j = 0; j < 10; j++) mem[j] = 32'h5A5A5A5A;
    @(negedge clk);
    rst_n = 1'b1;
    read(0, 32, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
